// File: rtl/cordic_coef_gen_if.sv
// ----------------------------------------------------------------------------
// cordic_coef_gen_if
// Handshake/bus bundle between the configuration loader (master) and the
// CORDIC coefficient generator (slave).
//   i_start  loader -> gen  start request
//   i_mode   loader -> gen  0 = circular, 1 = hyperbolic
//   i_seed   loader -> gen  first coefficient
//   i_ready  sink   -> gen  downstream accepts current coefficient
//   o_data   gen    -> sink coefficient
//   o_index  gen    -> sink iteration index of o_data
//   o_valid  gen    -> sink o_data/o_index valid
//   o_last   gen    -> sink final coefficient of the run
//   o_busy   gen    -> loader run in progress
//   o_done   gen    -> loader one-cycle completion pulse
// ----------------------------------------------------------------------------
interface cordic_coef_gen_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  i_start;
    logic                  i_mode;
    logic [DATA_WIDTH-1:0] i_seed;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [5:0]            o_index;
    logic                  o_valid;
    logic                  o_last;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        output i_start, i_mode, i_seed, i_ready,
        input  o_data, o_index, o_valid, o_last, o_busy, o_done
    );

    modport slave (
        input  i_start, i_mode, i_seed, i_ready,
        output o_data, o_index, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/cordic_coef_gen.sv
// ----------------------------------------------------------------------------
// cordic_coef_gen
// Streams N_PE CORDIC angle coefficients (atan(2^-i) circular, atanh(2^-i)
// hyperbolic with repeats at i=4 and i=13), one per valid/ready transfer.
// Entry 0 is the latched seed; later entries use x -/+ t with t ~= c/3
// (truncated Taylor term) up to TAYLOR_LAST, then the small-angle 2^-i.
//
// Ports:
//   i_clk   clock
//   i_rstn  synchronous active-low reset
//   bus     cordic_coef_gen_if.slave (start/mode/seed/ready in,
//           data/index/valid/last/busy/done out)
//
// Build option: define CORDIC_COEF_ROUND_EN to round-half-up each t-term
// instead of truncating.
// ----------------------------------------------------------------------------
module cordic_coef_gen #(
    parameter int N_PE        = 16,
    parameter int DATA_WIDTH  = 18,
    parameter int FRAC_BITS   = 12,
    parameter int TAYLOR_LAST = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    cordic_coef_gen_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] UNIT     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ONE      = UNIT << FRAC_BITS;
    localparam logic [5:0]            LAST_CNT = 6'(N_PE - 1);
    localparam logic [5:0]            TL       = 6'(TAYLOR_LAST);

    // Coefficient for iteration index i (entries after the seed).
    // Shifts beyond the width naturally yield 0, so no wrap guard is needed.
    function automatic logic [DATA_WIDTH-1:0] coef_f(input logic [5:0] i,
                                                     input logic       hyp);
        logic [DATA_WIDTH-1:0] x, c, t;
        logic [7:0]            sh3;
        x   = ONE >> i;
        sh3 = 8'(i) * 8'd3;
        c   = ONE >> sh3;
`ifdef CORDIC_COEF_ROUND_EN
        t = ((c + (UNIT << 1)) >> 2) + ((c + (UNIT << 3)) >> 4)
          + ((c + (UNIT << 5)) >> 6) + ((c + (UNIT << 7)) >> 8);
`else
        t = (c >> 2) + (c >> 4) + (c >> 6) + (c >> 8);
`endif
        if (i > TL)
            return x;
        else if (hyp)
            return x + t;
        else
            return x - t;
    endfunction

    state_t                state_q;
    logic                  mode_q;
    logic                  rep_q;      // current index already emitted once (hyperbolic repeat)
    logic [5:0]            cnt_q;      // position of the presented entry within the run
    logic [DATA_WIDTH-1:0] o_data_q;
    logic [5:0]            o_index_q;
    logic                  o_valid_q;
    logic                  o_last_q;
    logic                  o_busy_q;
    logic                  o_done_q;

    logic [5:0]            idx_d;
    logic                  rep_d;
    logic [5:0]            cnt_d;
    logic [DATA_WIDTH-1:0] coef_d;

    // Next index: hyperbolic mode revisits 4 and 13 once before moving on.
    always_comb begin
        idx_d = o_index_q + 6'd1;
        rep_d = 1'b0;
        if (mode_q && !rep_q && (o_index_q == 6'd4 || o_index_q == 6'd13)) begin
            idx_d = o_index_q;
            rep_d = 1'b1;
        end
        cnt_d  = cnt_q + 6'd1;
        coef_d = coef_f(idx_d, mode_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            rep_q     <= 1'b0;
            cnt_q     <= '0;
            o_data_q  <= '0;
            o_index_q <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_busy_q  <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_done_q <= 1'b0;
                    if (bus.i_start) begin
                        mode_q    <= bus.i_mode;
                        rep_q     <= 1'b0;
                        cnt_q     <= '0;
                        o_data_q  <= bus.i_seed;
                        o_index_q <= bus.i_mode ? 6'd1 : 6'd0;
                        o_valid_q <= 1'b1;
                        o_last_q  <= 1'b0;
                        o_busy_q  <= 1'b1;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    if (o_valid_q && bus.i_ready) begin
                        if (o_last_q) begin
                            o_valid_q <= 1'b0;
                            o_last_q  <= 1'b0;
                            o_busy_q  <= 1'b0;
                            o_done_q  <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            o_index_q <= idx_d;
                            rep_q     <= rep_d;
                            o_data_q  <= coef_d;
                            cnt_q     <= cnt_d;
                            o_last_q  <= (cnt_d == LAST_CNT);
                        end
                    end
                end
                DONE: begin
                    o_done_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_index = o_index_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_last  = o_last_q;
    assign bus.o_busy  = o_busy_q;
    assign bus.o_done  = o_done_q;

endmodule

// File: tb/tb_cordic_coef_gen.sv
// ----------------------------------------------------------------------------
// tb_cordic_coef_gen
// Self-checking bench: drives runs through the interface, collects transfers
// and compares them against a reference model of the coefficient sequence.
// ----------------------------------------------------------------------------
module tb_cordic_coef_gen;

    localparam int N  = 16;
    localparam int DW = 18;
    localparam int FB = 12;
    localparam int TL = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cordic_coef_gen_if #(.DATA_WIDTH(DW)) bus();

    cordic_coef_gen #(.N_PE(N), .DATA_WIDTH(DW), .FRAC_BITS(FB), .TAYLOR_LAST(TL)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    int got_data[$], got_idx[$], got_last[$];
    int hold_data[$], hold_idx[$];
    int exp_data[$], exp_idx[$];
    logic first_valid, done1, busy1, valid1, done2;

    // Reference value of the coefficient at index i, straight from the rules.
    function automatic int model_val(int i, bit hyp);
        int one, x, c, t, v;
        int sh[4] = '{2, 4, 6, 8};
        one = 1 << FB;
        x = (i >= DW) ? 0 : (one >> i);
        c = (3 * i >= DW) ? 0 : (one >> (3 * i));
        t = 0;
        foreach (sh[k]) begin
`ifdef CORDIC_COEF_ROUND_EN
            t += (c + (1 << (sh[k] - 1))) >> sh[k];
`else
            t += c >> sh[k];
`endif
        end
        if (i <= TL) v = hyp ? x + t : x - t;
        else         v = x;
        return v & ((1 << DW) - 1);
    endfunction

    // Full expected stream: index list with one repeat each of 4 and 13.
    function automatic void build_model(bit hyp, int seed);
        bit repeated[64];
        int i;
        exp_data.delete();
        exp_idx.delete();
        foreach (repeated[k]) repeated[k] = 1'b0;
        i = hyp ? 1 : 0;
        for (int k = 0; k < N; k++) begin
            exp_idx.push_back(i);
            exp_data.push_back(k == 0 ? seed : model_val(i, hyp));
            if (hyp && (i == 4 || i == 13) && !repeated[i]) repeated[i] = 1'b1;
            else i++;
        end
    endfunction

    // Drives one run and records every transfer; optional mid-run start
    // injection and a 3-cycle stall on a chosen index.
    task automatic run(input bit hyp, input int seed, input int ready_pct,
                       input int inject_at, input int stall_idx, input int max_cycles);
        int  cyc = 0;
        int  stall = 0;
        bit  fin = 0;
        bit  first = 1;
        bit  injected = 0;
        got_data.delete(); got_idx.delete(); got_last.delete();
        hold_data.delete(); hold_idx.delete();
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_mode  = hyp;
        bus.i_seed  = DW'(seed);
        while (!fin && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0;
            if (first) begin first_valid = bus.o_valid; first = 0; end
            if (inject_at >= 0 && got_data.size() == inject_at && !injected) begin
                bus.i_start = 1'b1;
                bus.i_mode  = ~hyp;
                bus.i_seed  = DW'($urandom);
                injected    = 1;
            end
            if (bus.o_valid && stall_idx >= 0 && int'(bus.o_index) == stall_idx && stall < 3) begin
                bus.i_ready = 1'b0;
                stall++;
                hold_data.push_back(int'(bus.o_data));
                hold_idx.push_back(int'(bus.o_index));
            end else begin
                bus.i_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (bus.o_valid && bus.i_ready) begin
                got_data.push_back(int'(bus.o_data));
                got_idx.push_back(int'(bus.o_index));
                got_last.push_back(int'(bus.o_last));
                if (bus.o_last) fin = 1;
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL run_timeout: got %0d transfers, required %0d", got_data.size(), N);
        end else begin
            @(negedge clk);
            bus.i_start = 1'b0;
            bus.i_ready = 1'b0;
            done1 = bus.o_done; busy1 = bus.o_busy; valid1 = bus.o_valid;
            @(negedge clk);
            done2 = bus.o_done;
        end
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_last, bus.o_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: v/b/l/d=%b required 0000",
                     {bus.o_valid, bus.o_busy, bus.o_last, bus.o_done});
        end
        checks++;
        if (bus.o_data !== '0 || bus.o_index !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%0d index=%0d required 0/0", bus.o_data, bus.o_index);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_circular;
`ifdef CORDIC_COEF_ROUND_EN
        int tbl[16] = '{3217, 1878, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0};
`else
        int tbl[16] = '{3217, 1878, 1003, 510, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0};
`endif
        run(0, 3217, 100, -1, -1, 200);
        checks++;
        if (first_valid !== 1'b1) begin
            errors++; $display("FAIL circ_latency: o_valid=%b required 1 one cycle after start", first_valid);
        end
        checks++;
        if (got_data.size() != N) begin
            errors++; $display("FAIL circ_count: %0d required %0d", got_data.size(), N);
        end
        for (int k = 0; k < got_data.size() && k < N; k++) begin
            checks++;
            if (got_data[k] != tbl[k] || got_idx[k] != k || got_last[k] != int'(k == N-1)) begin
                errors++;
                $display("FAIL circ_entry%0d: data=%0d idx=%0d last=%0d required %0d/%0d/%0d",
                         k, got_data[k], got_idx[k], got_last[k], tbl[k], k, int'(k == N-1));
            end
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || valid1 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL circ_done: done=%b busy=%b valid=%b done_next=%b required 1/0/0/0",
                     done1, busy1, valid1, done2);
        end
    endtask

    task automatic test_hyperbolic;
        int idx_tbl[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
        run(1, 2250, 100, -1, -1, 200);
        build_model(1, 2250);
        checks++;
        if (got_data.size() != N) begin
            errors++; $display("FAIL hyp_count: %0d required %0d", got_data.size(), N);
        end
        for (int k = 0; k < got_data.size() && k < N; k++) begin
            checks++;
            if (got_idx[k] != idx_tbl[k] || got_data[k] != exp_data[k]) begin
                errors++;
                $display("FAIL hyp_entry%0d: data=%0d idx=%0d required %0d/%0d",
                         k, got_data[k], got_idx[k], exp_data[k], idx_tbl[k]);
            end
        end
        if (got_data.size() == N) begin
            checks++;
            if (got_data[1] != 1045 || got_data[3] != 256 || got_data[4] != 256) begin
                errors++;
                $display("FAIL hyp_known: idx2=%0d idx4a=%0d idx4b=%0d required 1045/256/256",
                         got_data[1], got_data[3], got_data[4]);
            end
        end
    endtask

    task automatic test_backpressure;
        run(0, 3217, 100, -1, 2, 200);
        build_model(0, 3217);
        checks++;
        if (hold_data.size() != 3) begin
            errors++; $display("FAIL bp_stall_cycles: %0d required 3", hold_data.size());
        end
        foreach (hold_data[k]) begin
            checks++;
            if (hold_data[k] != 1003 || hold_idx[k] != 2) begin
                errors++;
                $display("FAIL bp_hold%0d: data=%0d idx=%0d required 1003/2", k, hold_data[k], hold_idx[k]);
            end
        end
        checks++;
        if (got_data != exp_data || got_idx != exp_idx) begin
            errors++; $display("FAIL bp_stream: %0d entries differ from required stream", got_data.size());
        end
    endtask

    task automatic test_start_ignored;
        run(0, 3217, 100, 5, -1, 200);
        build_model(0, 3217);
        checks++;
        if (got_data != exp_data || got_idx != exp_idx) begin
            errors++; $display("FAIL start_ignored_stream: %0d entries differ from circular stream", got_data.size());
        end
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL start_ignored_done: done=%b required 1", done1);
        end
    endtask

    task automatic test_reset_midrun;
        int  cyc = 0;
        int  seed;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_mode = 1'b0; bus.i_seed = DW'(1234);
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_ready = 1'b1;
        while (!(bus.o_valid && bus.o_index == 6'd6) && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc >= 50) begin
            errors++; $display("FAIL midrun_reach_entry7: timed out, index=%0d", bus.o_index);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_last, bus.o_done} !== 4'b0) begin
            errors++;
            $display("FAIL midrun_reset: v/b/l/d=%b required 0000",
                     {bus.o_valid, bus.o_busy, bus.o_last, bus.o_done});
        end
        rstn = 1'b1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++; $display("FAIL midrun_no_done: done=%b required 0", bus.o_done);
        end
        seed = int'($urandom_range(0, (1 << DW) - 1));
        run(0, seed, 100, -1, -1, 200);
        build_model(0, seed);
        checks++;
        if (got_data != exp_data || got_idx != exp_idx) begin
            errors++; $display("FAIL midrun_restart: %0d entries differ, first idx %0d",
                               got_data.size(), got_idx.size() > 0 ? got_idx[0] : -1);
        end
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 6; r++) begin
            bit hyp  = 1'($urandom_range(0, 1));
            int seed = int'($urandom_range(0, (1 << DW) - 1));
            int pct  = int'($urandom_range(30, 100));
            run(hyp, seed, pct, -1, -1, 2000);
            build_model(hyp, seed);
            checks++;
            if (got_data != exp_data || got_idx != exp_idx) begin
                errors++;
                $display("FAIL b2b_run%0d: mode=%0d seed=%0d ready%%=%0d, %0d entries differ from model",
                         r, hyp, seed, pct, got_data.size());
            end
            checks++;
            if (got_last.size() != N || got_last[N-1] != 1 || done1 !== 1'b1 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_end%0d: transfers=%0d done=%b done_next=%b required %0d/1/0",
                         r, got_last.size(), done1, done2, N);
            end
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_seed  = '0;
        bus.i_ready = 1'b0;
        rstn        = 1'b0;
        test_reset;
        test_circular;
        test_hyperbolic;
        test_backpressure;
        test_start_ignored;
        test_reset_midrun;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_coef_gen.md
Name: cordic_coef_gen

Overview:
Parametrised angle-coefficient generator for the CORDIC PE chain. It streams N_PE per-stage coefficients, one per accepted handshake.
- Circular mode: atan(2^-i).
- Hyperbolic mode: atanh(2^-i), including the mandatory iteration repeats.
- Coefficients come from a seed input, then a truncated Taylor series, then the small-angle identity.
- Sits between the configuration loader and the PE coefficient registers, and supports downstream backpressure.

Parameters:
- N_PE, 16: number of coefficients emitted per run (2..64).
- DATA_WIDTH, 18: coefficient width, unsigned.
- FRAC_BITS, 12: fractional bits; ONE = 1<<FRAC_BITS; requires FRAC_BITS < DATA_WIDTH.
- TAYLOR_LAST, 5: highest index using the Taylor correction; indices above it emit 2^-i only.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, synchronous, active-low; clock i_clk.
- i_start  in  1  start request, honoured only when idle.
- i_mode  in  1  0 = circular, 1 = hyperbolic; latched on accepted start.
- i_seed  in  DATA_WIDTH  first coefficient (atan(1) or atanh(0.5)); latched on accepted start.
- i_ready  in  1  downstream accepts the current coefficient.
- o_data  out  DATA_WIDTH  coefficient.
- o_index  out  6  iteration index i of o_data.
- o_valid  out  1  o_data/o_index valid.
- o_last  out  1  o_data is the N_PE-th coefficient.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
Reset:
- All outputs are 0, state IDLE, counters 0.
- Reset mid-run aborts immediately; no o_done is produced.

States: IDLE, EMIT, DONE.
- IDLE -> EMIT when i_start=1:
  - latch i_mode and i_seed;
  - set o_busy=1;
  - next cycle o_valid=1 with o_data=seed, o_index=0 (circular) or 1 (hyperbolic).
  - First-coefficient latency: 1 cycle after start.
- EMIT handshake:
  - A coefficient is transferred on a cycle with o_valid & i_ready.
  - Without transfer, o_data/o_index/o_last hold stable.
  - After a transfer that is not last, the next coefficient is registered and o_valid stays 1. Back-to-back throughput is 1 per cycle.
- EMIT -> DONE on transfer with o_last=1: o_valid=0, o_last=0.
- DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE. A new start is accepted from the following cycle.
- i_start while busy or in DONE is ignored; the latched mode and seed are unaffected.

Index sequence:
- Circular: 0, 1, …, N_PE-1.
- Hyperbolic: starts at 1. Indices 4 and 13 are each emitted twice (repeat flag per index). Sequence is truncated to N_PE entries.
  - With N_PE=16: 1, 2, 3, 4, 4, 5, …, 13, 13, 14.
- Emitted count is always N_PE. o_last is asserted on entry N_PE.

Arithmetic, for emitted entry k>0 with index i:
- x = ONE >> i.
- c = ONE >> 3i; c = 0 when 3i >= DATA_WIDTH.
- t = (c>>2) + (c>>4) + (c>>6) + (c>>8), which approximates c/3.
- For i <= TAYLOR_LAST: circular gives x - t; hyperbolic gives x + t.
- For i > TAYLOR_LAST: x.
- Shift amounts >= DATA_WIDTH yield 0, with no wrap. Result is unsigned, DATA_WIDTH bits, never negative for legal parameters.

Optional Feature:
CORDIC_COEF_ROUND_EN
- Defined: each of the four t-terms uses round-half-up, (c + (1<<(s-1))) >> s. The x shift is unaffected.
- Undefined: plain truncating shifts, as above.

Test Plan:
- Circular, seed=3217, i_ready=1, defaults, no macro -> o_data sequence:
  - 3217, 1878, 1003, 510, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0;
  - o_index 0..15; o_last on 16th; o_done pulse the cycle after; o_busy low that cycle.
- Hyperbolic, seed=2250, i_ready=1 -> o_index 1,2,3,4,4,5,…,13,13,14; entry with index 2 = 1045; both index-4 entries = 256; 16 transfers total.
- Backpressure: i_ready low 3 cycles while index-2 coefficient is presented -> o_data=1003 and o_index=2 held stable; no skipped or duplicated entry once i_ready returns.
- i_start pulsed mid-run with i_mode=1 and a new seed -> ignored; circular sequence completes unchanged.
- i_rstn low during entry 7 -> next cycle o_valid=o_busy=o_last=o_done=0; a fresh start restarts at index 0.
- With CORDIC_COEF_ROUND_EN, circular -> index-3 entry = 509 (truncating build gives 510); index-1 entry = 1878.
